// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble digit correction: adds 3 when the digit is 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BCD_BLANK_EN adds the registered per-digit leading-zero blank output.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]         blank
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = DIGIT_W * DIGITS;

    // Handshake: start is taken on any rising edge where the FSM is IDLE
    // (including the done cycle); busy covers the WIDTH shift edges and done
    // pulses for one cycle once the result is on bcd.
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q,    sh_d;
    logic [SCR_W-1:0]   scr_q,   scr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SCR_W-1:0]   bcd_q,   bcd_d;
    logic               done_q,  done_d;

    logic [SCR_W-1:0]       adj;
    logic [SCR_W+WIDTH-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign shifted = {adj, sh_q} << 1;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d  = shifted[WIDTH-1:0];
                scr_d = shifted[SCR_W+WIDTH-1:WIDTH];
                cnt_d = cnt_q - 1'b1;
                // Last shift: the finished digits go straight to bcd.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted[SCR_W+WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              upper_zero;

    // Digit 0 is never blanked so a zero result still shows "0".
    always_comb begin
        blank_d    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (bcd_d[i*DIGIT_W +: DIGIT_W] == '0);
            blank_d[i] = upper_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule
